// File: rtl/vga_mem_arbiter_n.sv
// vga_mem_arbiter_n: shares one synchronous video SRAM between a CPU Wishbone port and NCH display read channels
module vga_mem_arbiter_n #(
   parameter int NCH    = 2,
   parameter int AW     = 17,
   parameter int DW     = 16,
   parameter int STARVE = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [AW-1:0]     wb_adr_i,
   input  logic [DW/8-1:0]   wb_sel_i,
   input  logic              wb_we_i,
   input  logic [DW-1:0]     wb_dat_i,
   output logic [DW-1:0]     wb_dat_o,
   input  logic              wb_stb_i,
   output logic              wb_ack_o,
   input  logic [NCH*AW-1:0] csr_adr_i,
   input  logic [NCH-1:0]    csr_stb_i,
   output logic [NCH-1:0]    csr_gnt_o,
   output logic [NCH-1:0]    csr_vld_o,
   output logic [DW-1:0]     csr_dat_o,
   output logic [AW-1:0]     csrm_adr_o,
   output logic [DW/8-1:0]   csrm_sel_o,
   output logic              csrm_we_o,
   output logic [DW-1:0]     csrm_dat_o,
   input  logic [DW-1:0]     csrm_dat_i
);
   logic [NCH-1:0] gnt, rrg, vld_q, vld_d;
   logic           cpu_elig, forced, cpu_gnt, rd_q, rd_d, ack_q, ack_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [2:0]     rr_q, rr_d, rrn;
   logic [AW-1:0]  adr_q, adr_d, adr_mux;
   logic [DW-1:0]  wbd_q, wbd_d;
   int             best, pos;
   always_comb begin
      cpu_elig = wb_stb_i && !rd_q && !ack_q;
      forced   = cpu_elig && cnt_q == 8'(STARVE-1);
      best     = NCH;
      pos      = 0;
      rrg      = '0;
      rrn      = rr_q;
      // rotated search: distance from rr_ptr, lowest distance wins
      for (int k = 1; k < NCH; k++) begin
         pos = (k >= int'(rr_q)) ? k - int'(rr_q) : k - int'(rr_q) + NCH - 1;
         if (csr_stb_i[k] && pos < best) begin
            best   = pos;
            rrg    = '0;
            rrg[k] = 1'b1;
            rrn    = (k == NCH-1) ? 3'd1 : 3'(k+1);
         end
      end
      cpu_gnt = !wb_rst_i && (forced || (!csr_stb_i[0] && rrg == '0 && cpu_elig));
      gnt     = (wb_rst_i || forced) ? '0 : csr_stb_i[0] ? NCH'(1) : rrg;
      rr_d    = (!wb_rst_i && !forced && !csr_stb_i[0] && |rrg) ? rrn : rr_q;
      adr_mux = adr_q;
      for (int k = 0; k < NCH; k++)
         if (gnt[k]) adr_mux = csr_adr_i[k*AW +: AW];
      csrm_adr_o = cpu_gnt ? wb_adr_i : adr_mux;
      csrm_sel_o = cpu_gnt ? wb_sel_i : |gnt ? '1 : '0;
      csrm_we_o  = cpu_gnt && wb_we_i;
      csrm_dat_o = cpu_gnt ? wb_dat_i : '0;
      cnt_d = (!cpu_elig || cpu_gnt) ? 8'd0 : forced ? cnt_q : cnt_q + 8'd1;
      rd_d  = cpu_gnt && !wb_we_i;
      ack_d = (cpu_gnt && wb_we_i) || rd_q;
      wbd_d = rd_q ? csrm_dat_i : wbd_q;
      vld_d = gnt;
      adr_d = csrm_adr_o;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         vld_q <= '0;
         rd_q  <= 1'b0;
         ack_q <= 1'b0;
         cnt_q <= '0;
         rr_q  <= 3'd1;
         adr_q <= '0;
         wbd_q <= '0;
      end else begin
         vld_q <= vld_d;
         rd_q  <= rd_d;
         ack_q <= ack_d;
         cnt_q <= cnt_d;
         rr_q  <= rr_d;
         adr_q <= adr_d;
         wbd_q <= wbd_d;
      end
   end
   assign csr_gnt_o = gnt;
   assign csr_vld_o = vld_q;
   assign csr_dat_o = |vld_q ? csrm_dat_i : '0;
   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = wbd_q;
endmodule

// File: tb/tb_vga_mem_arbiter_n.sv
// tb_vga_mem_arbiter_n: directed checks of the arbiter with NCH=3 against a synchronous SRAM model
module tb_vga_mem_arbiter_n;
   localparam int NCH = 3, AW = 17, DW = 16;
   logic            clk = 1'b0, rst;
   logic [AW-1:0]   wb_adr;
   logic [1:0]      wb_sel;
   logic            wb_we, wb_stb, wb_ack;
   logic [DW-1:0]   wb_wdat, wb_rdat;
   logic [NCH*AW-1:0] csr_adr;
   logic [NCH-1:0]  csr_stb, csr_gnt, csr_vld;
   logic [DW-1:0]   csr_dat;
   logic [AW-1:0]   m_adr;
   logic [1:0]      m_sel;
   logic            m_we;
   logic [DW-1:0]   m_wdat, m_rdat;
   int checks = 0, errs = 0;
   logic [15:0] wmem [int];
   logic [15:0] wtmp;
   logic [2:0] sb [15];
   logic [2:0] eg [15];

   vga_mem_arbiter_n #(.NCH(NCH), .AW(AW), .DW(DW), .STARVE(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_sel_i(wb_sel),
      .wb_we_i(wb_we), .wb_dat_i(wb_wdat), .wb_dat_o(wb_rdat), .wb_stb_i(wb_stb),
      .wb_ack_o(wb_ack), .csr_adr_i(csr_adr), .csr_stb_i(csr_stb), .csr_gnt_o(csr_gnt),
      .csr_vld_o(csr_vld), .csr_dat_o(csr_dat), .csrm_adr_o(m_adr), .csrm_sel_o(m_sel),
      .csrm_we_o(m_we), .csrm_dat_o(m_wdat), .csrm_dat_i(m_rdat));

   always #5 clk = ~clk;

   function automatic logic [15:0] rdm(input logic [AW-1:0] a);
      return wmem.exists(int'(a)) ? wmem[int'(a)] : (a[15:0] ^ 16'h5A00);
   endfunction

   always @(posedge clk) begin
      if (m_we) begin
         wtmp = rdm(m_adr);
         if (m_sel[0]) wtmp[7:0] = m_wdat[7:0];
         if (m_sel[1]) wtmp[15:8] = m_wdat[15:8];
         wmem[int'(m_adr)] = wtmp;
      end
      m_rdat <= rdm(m_adr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nx;
      @(negedge clk);
   endtask

   task automatic set_ch(input int k, input logic [AW-1:0] a);
      csr_adr[k*AW +: AW] = a;
   endtask

   initial begin
      rst = 1'b1; wb_adr = '0; wb_sel = '0; wb_we = 1'b1; wb_stb = 1'b1; wb_wdat = '0;
      csr_adr = '0; csr_stb = 3'b111;
      nx(); nx(); #1;
      chk("rst_gnt", 32'(csr_gnt), 0);
      chk("rst_we", 32'(m_we), 0);
      wb_we = 1'b0; wb_stb = 1'b0; csr_stb = '0;
      nx(); rst = 1'b0; #1;
      chk("rst_ack", 32'(wb_ack), 0);
      chk("rst_wbdat", 32'(wb_rdat), 0);
      chk("rst_vld", 32'(csr_vld), 0);
      chk("rst_csrdat", 32'(csr_dat), 0);
      chk("rst_gnt2", 32'(csr_gnt), 0);
      chk("rst_sel", 32'(m_sel), 0);
      chk("rst_madr", 32'(m_adr), 0);
      chk("rst_mdat", 32'(m_wdat), 0);
      // CPU write 0x10 <= BEEF
      nx(); wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 17'h10; wb_wdat = 16'hBEEF; wb_sel = 2'b11; #1;
      chk("wr_we", 32'(m_we), 1);
      chk("wr_adr", 32'(m_adr), 32'h10);
      chk("wr_dat", 32'(m_wdat), 32'hBEEF);
      chk("wr_sel", 32'(m_sel), 3);
      chk("wr_ack0", 32'(wb_ack), 0);
      nx(); #1;
      chk("wr_ack1", 32'(wb_ack), 1);
      chk("wr_we1", 32'(m_we), 0);
      chk("wr_sel1", 32'(m_sel), 0);
      wb_stb = 1'b0;
      nx(); #1;
      chk("wr_ack2", 32'(wb_ack), 0);
      // CPU read 0x10
      nx(); wb_stb = 1'b1; wb_we = 1'b0; #1;
      chk("rd_sel", 32'(m_sel), 3);
      chk("rd_we", 32'(m_we), 0);
      chk("rd_adr", 32'(m_adr), 32'h10);
      nx(); #1;
      chk("rd_ack1", 32'(wb_ack), 0);
      chk("rd_idle_sel", 32'(m_sel), 0);
      chk("rd_hold_adr", 32'(m_adr), 32'h10);
      nx(); #1;
      chk("rd_ack2", 32'(wb_ack), 1);
      chk("rd_dat", 32'(wb_rdat), 32'hBEEF);
      wb_stb = 1'b0;
      nx(); #1;
      chk("rd_ack3", 32'(wb_ack), 0);
      chk("rd_dat_hold", 32'(wb_rdat), 32'hBEEF);
      // channel 0 streaming 0x100..0x10F
      for (int i = 0; i <= 16; i++) begin
         nx();
         set_ch(0, 17'(32'h100 + i));
         csr_stb = (i < 16) ? 3'b001 : 3'b000;
         #1;
         if (i < 16) begin
            chk("c0_gnt", 32'(csr_gnt), 1);
            chk("c0_adr", 32'(m_adr), 32'h100 + i);
         end else chk("c0_gnt_end", 32'(csr_gnt), 0);
         if (i > 0) begin
            chk("c0_vld", 32'(csr_vld), 1);
            chk("c0_dat", 32'(csr_dat), (32'h100 + i - 1) ^ 32'h5A00);
         end
      end
      // round robin between 1 and 2, channel 0 cutting in
      sb = '{3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
      eg = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 7; i++) begin
         nx();
         csr_stb = sb[i];
         set_ch(1, 17'(32'h200 + i));
         set_ch(2, 17'(32'h300 + i));
         #1;
         chk("rr_gnt", 32'(csr_gnt), 32'(eg[i]));
         if (i > 0) chk("rr_vld", 32'(csr_vld), 32'(eg[i-1]));
         if (i == 2) chk("rr_dat", 32'(csr_dat), 32'h5901);
      end
      // starvation: CPU reads against continuous channel 0
      for (int c = 0; c < 20; c++) begin
         nx();
         csr_stb = 3'b001; wb_stb = 1'b1; wb_we = 1'b0;
         if (c == 0) wb_adr = 17'h10;
         if (c == 10) wb_adr = 17'h105;
         #1;
         chk("st_gnt", 32'(csr_gnt), (c == 7 || c == 17) ? 0 : 1);
         chk("st_ack", 32'(wb_ack), (c == 9 || c == 19) ? 1 : 0);
         if (c == 9) chk("st_dat1", 32'(wb_rdat), 32'hBEEF);
         if (c == 19) chk("st_dat2", 32'(wb_rdat), 32'h5B05);
      end
      nx(); csr_stb = '0; wb_stb = 1'b0; #1;
      chk("st_ack_end", 32'(wb_ack), 0);
      // write with stb dropped after grant, low byte only
      nx(); wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 17'h20; wb_wdat = 16'h1234; wb_sel = 2'b01; #1;
      chk("wd_we", 32'(m_we), 1);
      chk("wd_sel", 32'(m_sel), 1);
      nx(); wb_stb = 1'b0; #1;
      chk("wd_ack1", 32'(wb_ack), 1);
      chk("wd_we1", 32'(m_we), 0);
      nx(); #1;
      chk("wd_ack2", 32'(wb_ack), 0);
      chk("wd_we2", 32'(m_we), 0);
      nx(); wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; #1;
      nx(); #1;
      nx(); #1;
      chk("wd_rack", 32'(wb_ack), 1);
      chk("wd_rdat", 32'(wb_rdat), 32'h5A34);
      wb_stb = 1'b0;
      // reset right after a CPU read grant
      nx(); wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 17'h10; #1;
      chk("rr_rd_sel", 32'(m_sel), 3);
      nx(); rst = 1'b1; wb_stb = 1'b0; csr_stb = 3'b001; #1;
      chk("rs_gnt", 32'(csr_gnt), 0);
      chk("rs_sel", 32'(m_sel), 0);
      nx(); rst = 1'b0; csr_stb = '0; #1;
      chk("rs_ack", 32'(wb_ack), 0);
      chk("rs_vld", 32'(csr_vld), 0);
      chk("rs_wbdat", 32'(wb_rdat), 0);
      nx(); #1;
      chk("rs_ack2", 32'(wb_ack), 0);
      // reset clears rr_ptr and starve_cnt
      sb = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b110, 3'b110, 3'b110,
             3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110};
      eg = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b100, 3'b010,
             3'b100, 3'b010, 3'b100, 3'b010, 3'b000, 3'b100, 3'b010};
      for (int c = 0; c < 15; c++) begin
         nx();
         rst = (c == 4);
         csr_stb = sb[c]; wb_stb = 1'b1; wb_we = 1'b0;
         #1;
         chk("rs2_gnt", 32'(csr_gnt), 32'(eg[c]));
         chk("rs2_ack", 32'(wb_ack), (c == 14) ? 1 : 0);
         if (c == 14) chk("rs2_dat", 32'(wb_rdat), 32'hBEEF);
      end
      nx(); csr_stb = '0; wb_stb = 1'b0; #1;
      chk("rs2_ack_end", 32'(wb_ack), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
